// File: rtl/dffram_mbist.sv
// dffram_mbist: March C- self-test controller driving the DFFRAM256x32 port.
// Runs E0..E5 back to back, one RAM operation per cycle, and compares every
// read RD_LAT edges after it is issued. Miscompares never stop the run.
// Optional first-failure capture (fail_addr/fail_elem/fail_xor) is built only
// when DFFRAM_MBIST_DIAG_EN is defined.
module dffram_mbist #(
    parameter int AWIDTH = 8,
    parameter int WSIZE  = 4,
    parameter int RD_LAT = 1
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [7:0]            err_cnt,
    output logic                  EN0,
    output logic [WSIZE-1:0]      WE0,
    output logic [AWIDTH-1:0]     A0,
    output logic [WSIZE*8-1:0]    Di0,
    input  logic [WSIZE*8-1:0]    Do0
`ifdef DFFRAM_MBIST_DIAG_EN
    ,
    output logic [AWIDTH-1:0]     fail_addr,
    output logic [2:0]            fail_elem,
    output logic [WSIZE*8-1:0]    fail_xor
`endif
);

    localparam int DW  = WSIZE * 8;
    localparam int DCW = $clog2(RD_LAT + 1);
    localparam logic [AWIDTH-1:0] AMAX  = '1;
    localparam logic [AWIDTH-1:0] AONE  = AWIDTH'(1);
    localparam logic [DCW-1:0]    DLAST = DCW'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state;
    logic [2:0]        elem;      // March element of the op currently on the port
    logic              ph;        // 0 = read half, 1 = write half of r/w elements
    logic [DCW-1:0]    dcnt;

    logic              accept, down, two_op, at_end, last_op, n_ph, n_wr, rd_now, miss;
    logic [2:0]        n_elem;
    logic [AWIDTH-1:0] n_addr;

    // Compare pipeline: valid, expected background, and (diag) address/element
    logic [RD_LAT-1:0] vld_pipe;
    logic [RD_LAT-1:0] exp_pipe;
`ifdef DFFRAM_MBIST_DIAG_EN
    logic [RD_LAT-1:0][AWIDTH-1:0] addr_pipe;
    logic [RD_LAT-1:0][2:0]        elem_pipe;
`endif

    assign accept = start && (state == IDLE || state == DONE);
    // A0 doubles as the address counter; a read is live whenever RUN shows EN0 without WE0
    assign rd_now = (state == RUN) && EN0 && (WE0 == '0);
    assign miss   = vld_pipe[RD_LAT-1] && (Do0 !== {DW{exp_pipe[RD_LAT-1]}});

    // Next-operation sequencer: phase, then address, then element
    always_comb begin
        down    = (elem == 3'd3) || (elem == 3'd4);
        two_op  = (elem != 3'd0) && (elem != 3'd5);
        at_end  = down ? (A0 == '0) : (A0 == AMAX);
        last_op = (elem == 3'd5) && at_end;
        n_elem  = elem;
        n_addr  = A0;
        n_ph    = 1'b0;
        if (two_op && !ph) begin
            n_ph = 1'b1;
        end else if (at_end) begin
            n_elem = elem + 3'd1;
            // elements 3 and 4 run downward and start from the top
            n_addr = (elem == 3'd2 || elem == 3'd3) ? AMAX : '0;
        end else begin
            n_addr = down ? A0 - AONE : A0 + AONE;
        end
        n_wr = (n_elem == 3'd0) || ((n_elem != 3'd5) && n_ph);
    end

    // Control FSM with registered RAM port; background written = element LSB
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state <= IDLE;
            elem  <= '0;
            ph    <= 1'b0;
            dcnt  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            EN0   <= 1'b0;
            WE0   <= '0;
            A0    <= '0;
            Di0   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        elem  <= '0;
                        ph    <= 1'b0;
                        EN0   <= 1'b1;
                        WE0   <= '1;
                        A0    <= '0;
                        Di0   <= '0;
                    end
                end
                RUN: begin
                    if (last_op) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                        EN0   <= 1'b0;
                        WE0   <= '0;
                    end else begin
                        elem <= n_elem;
                        ph   <= n_ph;
                        A0   <= n_addr;
                        WE0  <= n_wr ? '1 : '0;
                        if (n_wr) Di0 <= {DW{n_elem[0]}};
                    end
                end
                DRAIN: begin
                    if (dcnt == DLAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        dcnt <= dcnt + DCW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read tracking shift register; expected value is all-1 for E2/E4, all-0 otherwise
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            vld_pipe <= '0;
            exp_pipe <= '0;
`ifdef DFFRAM_MBIST_DIAG_EN
            addr_pipe <= '0;
            elem_pipe <= '0;
`endif
        end else begin
            vld_pipe[0] <= rd_now;
            exp_pipe[0] <= ~elem[0];
`ifdef DFFRAM_MBIST_DIAG_EN
            addr_pipe[0] <= A0;
            elem_pipe[0] <= elem;
`endif
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                exp_pipe[i] <= exp_pipe[i-1];
`ifdef DFFRAM_MBIST_DIAG_EN
                addr_pipe[i] <= addr_pipe[i-1];
                elem_pipe[i] <= elem_pipe[i-1];
`endif
            end
        end
    end

    // Result flags: cleared on accepted start, updated on each retiring miscompare
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            fail    <= 1'b0;
            err_cnt <= '0;
`ifdef DFFRAM_MBIST_DIAG_EN
            fail_addr <= '0;
            fail_elem <= '0;
            fail_xor  <= '0;
`endif
        end else if (accept) begin
            fail    <= 1'b0;
            err_cnt <= '0;
`ifdef DFFRAM_MBIST_DIAG_EN
            fail_addr <= '0;
            fail_elem <= '0;
            fail_xor  <= '0;
`endif
        end else if (miss) begin
            fail <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`ifdef DFFRAM_MBIST_DIAG_EN
            if (!fail) begin
                fail_addr <= addr_pipe[RD_LAT-1];
                fail_elem <= elem_pipe[RD_LAT-1];
                fail_xor  <= Do0 ^ {DW{exp_pipe[RD_LAT-1]}};
            end
`endif
        end
    end

endmodule

// File: tb/tb_dffram_mbist.sv
// tb_dffram_mbist: randomized fault-injection bench for dffram_mbist with a
// faultable RAM model, an element-level March C- reference and a scoreboard.
module tb_dffram_mbist;

    localparam int AW  = 8;
    localparam int WS  = 4;
    localparam int DW  = 32;
    localparam int N   = 256;
    localparam int RL  = 1;
    localparam int RUN_CYC = 10 * N + RL;

    logic          CLK = 1'b0;
    logic          RESETn = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, fail, EN0;
    logic [7:0]    err_cnt;
    logic [WS-1:0] WE0;
    logic [AW-1:0] A0;
    logic [DW-1:0] Di0;
    logic [DW-1:0] Do0 = '0;
`ifdef DFFRAM_MBIST_DIAG_EN
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic [DW-1:0] fail_xor;
`endif

    always #5 CLK = ~CLK;

    dffram_mbist #(.AWIDTH(AW), .WSIZE(WS), .RD_LAT(RL)) dut (
        .CLK(CLK), .RESETn(RESETn), .start(start),
        .busy(busy), .done(done), .fail(fail), .err_cnt(err_cnt),
        .EN0(EN0), .WE0(WE0), .A0(A0), .Di0(Di0), .Do0(Do0)
`ifdef DFFRAM_MBIST_DIAG_EN
        , .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_xor(fail_xor)
`endif
    );

    // typ: 0 none, 1 stuck-at (fa,fb,fv), 2 coupling fa->fa+1, 3 read bit-flip below lim
    typedef struct { int typ; int fa; int fb; int fv; int lim; } fault_t;
    typedef struct { int err; bit fail; int faddr; int felem; logic [31:0] fxor; } res_t;
    typedef struct { bit we; logic [7:0] a; logic [31:0] d; } op_t;

    fault_t      cfg = '{0, 0, 0, 0, 0};
    logic [31:0] mem  [N];
    logic [31:0] rmem [N];
    op_t         exp_ops [$];
    res_t        res_q [$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] f_store(input int a, input logic [31:0] d);
        logic [31:0] r;
        r = d;
        if (cfg.typ == 1 && a == cfg.fa) r[cfg.fb] = cfg.fv[0];
        return r;
    endfunction

    function automatic logic [31:0] f_read(input int a, input logic [31:0] d);
        logic [31:0] r;
        r = d;
        if (cfg.typ == 3 && a < cfg.lim) r[cfg.fb] = ~r[cfg.fb];
        return r;
    endfunction

    // Faultable single-port RAM, registered read
    always @(posedge CLK) begin
        if (EN0) begin
            if (WE0 != '0) begin
                mem[A0] <= f_store(int'(A0), Di0);
                if (cfg.typ == 2 && int'(A0) == cfg.fa) mem[cfg.fa + 1] <= f_store(cfg.fa + 1, Di0);
            end else begin
                Do0 <= f_read(int'(A0), mem[A0]);
            end
        end
    end

    // Element-level March C- on an abstract memory: expected op stream and result
    task automatic ref_run(output res_t r);
        int a;
        logic [31:0] bg, got;
        r.err = 0; r.fail = 1'b0; r.faddr = 0; r.felem = 0; r.fxor = '0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < N; k++) begin
                a = (e == 3 || e == 4) ? N - 1 - k : k;
                if (e != 0) begin
                    bg = (e == 2 || e == 4) ? 32'hFFFF_FFFF : 32'h0;
                    exp_ops.push_back('{1'b0, 8'(a), 32'h0});
                    got = f_read(a, rmem[a]);
                    if (got !== bg) begin
                        if (!r.fail) begin r.faddr = a; r.felem = e; r.fxor = got ^ bg; end
                        r.fail = 1'b1;
                        if (r.err < 255) r.err++;
                    end
                end
                if (e != 5) begin
                    bg = (e == 1 || e == 3) ? 32'hFFFF_FFFF : 32'h0;
                    exp_ops.push_back('{1'b1, 8'(a), bg});
                    rmem[a] = f_store(a, bg);
                    if (cfg.typ == 2 && a == cfg.fa) rmem[a + 1] = f_store(a + 1, bg);
                end
            end
        end
    endtask

    // Monitor: op stream checked every enabled cycle, results popped on done rising
    int   busy_cyc = 0;
    int   op_err = 0;
    int   ram_err;
    bit   busy_q = 1'b0, done_q = 1'b0;
    op_t  o;
    res_t e;
    always @(negedge CLK) begin
        if (busy && !busy_q) begin busy_cyc = 0; op_err = 0; end
        if (busy) busy_cyc++;
        if (EN0) begin
            if (exp_ops.size() == 0) op_err++;
            else begin
                o = exp_ops.pop_front();
                if (A0 !== o.a || (o.we ? (WE0 !== 4'hF || Di0 !== o.d) : (WE0 !== 4'h0))) op_err++;
            end
        end
        if (done && !done_q) begin
            if (res_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
            else begin
                e = res_q.pop_front();
                chk("err_cnt", err_cnt, e.err);
                chk("fail", fail, e.fail);
                chk("busy_cycles", busy_cyc, RUN_CYC);
                chk("op_stream_errs", op_err + exp_ops.size(), 0);
                ram_err = 0;
                for (int i = 0; i < N; i++) if (mem[i] !== rmem[i]) ram_err++;
                chk("final_ram_errs", ram_err, 0);
`ifdef DFFRAM_MBIST_DIAG_EN
                chk("fail_addr", fail_addr, e.faddr);
                chk("fail_elem", fail_elem, e.felem);
                chk("fail_xor", fail_xor, e.fxor);
`endif
            end
        end
        busy_q = busy;
        done_q = done;
    end

    task automatic pulse_start();
        @(posedge CLK); #1 start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
    endtask

    task automatic do_run(input fault_t f, input int spur);
        res_t r;
        int   n;
        cfg = f;
        ref_run(r);
        res_q.push_back(r);
        pulse_start();
        if (spur > 0) begin
            repeat (spur - 1) @(posedge CLK);
            #1 start = 1'b1;
            @(posedge CLK); #1 start = 1'b0;
        end
        n = 0;
        while (!done && n < RUN_CYC + 50) begin @(posedge CLK); #1; n++; end
        chk("done_timeout", done, 1);
        repeat (4) @(posedge CLK);
        #1;
        chk("err_hold", err_cnt, r.err);
        chk("fail_hold", fail, r.fail);
        chk("busy_after_done", busy, 0);
    endtask

    initial begin
        #(1_000_000);
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        fault_t f;
        #12;
        chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);   chk("rst_err", err_cnt, 0);
        chk("rst_en", EN0, 0);      chk("rst_we", WE0, 0);
        chk("rst_a", A0, 0);        chk("rst_di", Di0, 0);
        @(posedge CLK); #1 RESETn = 1'b1;
        repeat (2) @(posedge CLK);

        do_run('{0, 0, 0, 0, 0}, 0);
        for (int i = 0; i < N; i++) if (mem[i] !== 32'h0) chk("final_zero", mem[i], 0);
        chk("clean_fail", fail, 0);

        do_run('{1, 8'h3C, 5, 1, 0}, 0);
        chk("sa_err3", err_cnt, 3);
`ifdef DFFRAM_MBIST_DIAG_EN
        chk("sa_faddr", fail_addr, 8'h3C);
        chk("sa_felem", fail_elem, 1);
        chk("sa_fxor", fail_xor, 32'h20);
`endif
        do_run('{2, 8'h10, 0, 0, 0}, 0);
        chk("cf_fail", fail, 1);

        do_run('{3, 0, 0, 0, N}, 0);
        chk("sat_err", err_cnt, 8'hFF);

        do_run('{0, 0, 0, 0, 0}, 500);

        for (int k = 0; k < 5; k++) begin
            f.typ = int'($urandom_range(0, 3));
            f.fa  = int'($urandom_range(0, N - 2));
            f.fb  = int'($urandom_range(0, 31));
            f.fv  = int'($urandom_range(0, 1));
            f.lim = int'($urandom_range(0, 80));
            do_run(f, ($urandom_range(0, 1) == 1) ? int'($urandom_range(100, 2400)) : 0);
        end

        // Abort mid-run with reset, then a clean rerun
        cfg = '{3, 0, 0, 0, N};
        pulse_start();
        repeat (1000) @(posedge CLK);
        #2 RESETn = 1'b0;
        #1;
        chk("abort_en", EN0, 0);    chk("abort_we", WE0, 0);
        chk("abort_busy", busy, 0); chk("abort_done", done, 0);
        chk("abort_fail", fail, 0); chk("abort_err", err_cnt, 0);
        exp_ops.delete();
        @(posedge CLK); #1 RESETn = 1'b1;
        repeat (2) @(posedge CLK);
        do_run('{0, 0, 0, 0, 0}, 0);
        chk("rerun_fail", fail, 0);

        chk("results_drained", res_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
